// File: rtl/sd_pkg.sv
// Shared types and defaults for the SD request arbiter.
package sd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } sd_state_e;

  localparam logic [23:0] SD_TIMEOUT = 24'd2800000;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit at or after ptr_i, wrapping.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          valid_o,
  output logic [PW-1:0] idx_o
);

  // Scan from the farthest offset down so the nearest hit is assigned last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int off = N - 1; off >= 0; off--) begin
      if (req_i[(int'(ptr_i) + off) % N]) begin
        valid_o = 1'b1;
        idx_o   = PW'((int'(ptr_i) + off) % N);
      end
    end
  end

endmodule

// File: rtl/sd_arbiter.sv
// Multiplexes several SD sector requesters onto one user_io port,
// round-robin, with a watchdog on the acknowledge handshake.
module sd_arbiter
  import sd_pkg::*;
#(
  parameter int          CHANNELS = 3,
  parameter logic [23:0] TIMEOUT  = SD_TIMEOUT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [CHANNELS-1:0]    req_rd,
  input  logic [CHANNELS-1:0]    req_wr,
  input  logic [32*CHANNELS-1:0] req_lba,
  input  logic [8*CHANNELS-1:0]  req_buff_d,
  output logic [CHANNELS-1:0]    sd_rd,
  output logic [CHANNELS-1:0]    sd_wr,
  input  logic                   sd_ack,
  output logic [31:0]            sd_lba,
  output logic [7:0]             sd_buff_din,
  input  logic                   sd_buff_wr,
  output logic [CHANNELS-1:0]    ch_ack,
  output logic [CHANNELS-1:0]    ch_buff_wr,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  sd_state_e     state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] grant_q, grant_d;
  logic          rd_q, rd_d;
  logic [31:0]   lba_q, lba_d;
  logic [23:0]   cnt_q, cnt_d;
  logic          terr_q, terr_d;

  logic [CHANNELS-1:0] req_any;
  logic [CHANNELS-1:0] grant_oh;
  logic                pick_valid;
  logic [PW-1:0]       pick_idx;

  assign req_any  = req_rd | req_wr;
  assign grant_oh = CHANNELS'(1) << grant_q;

  rr_pick #(.N(CHANNELS), .PW(PW)) u_pick (
    .req_i   (req_any),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      rd_q    <= 1'b0;
      lba_q   <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      rd_q    <= rd_d;
      lba_q   <= lba_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    rd_d    = rd_q;
    lba_d   = lba_q;
    cnt_d   = cnt_q;
    terr_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A leftover ack from the previous transfer must clear before a new grant.
        if (!sd_ack && pick_valid) begin
          grant_d = pick_idx;
          rd_d    = req_rd[pick_idx];
          lba_d   = req_lba[32*pick_idx +: 32];
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sd_ack) begin
          state_d = ST_XFER;
        end else if (!req_any[grant_q]) begin
          state_d = ST_IDLE;
        end else if (cnt_q == TIMEOUT - 24'd1) begin
          state_d = ST_IDLE;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      ST_XFER: begin
        if (!sd_ack) begin
          state_d = ST_IDLE;
          ptr_d   = (grant_q == PW'(CHANNELS - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign sd_rd       = (state_q == ST_REQ && rd_q)  ? grant_oh : '0;
  assign sd_wr       = (state_q == ST_REQ && !rd_q) ? grant_oh : '0;
  assign sd_lba      = lba_q;
  assign sd_buff_din = req_buff_d[8*grant_q +: 8];
  assign ch_ack      = (busy && sd_ack)     ? grant_oh : '0;
  assign ch_buff_wr  = (busy && sd_buff_wr) ? grant_oh : '0;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_sd_arbiter.sv
// Directed and randomized checks of sd_arbiter against a queue-free request model.
module tb_sd_arbiter;
  localparam int CH = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [CH-1:0]   req_rd, req_wr;
  logic [32*CH-1:0] req_lba;
  logic [8*CH-1:0] req_buff_d;
  logic [CH-1:0]   sd_rd, sd_wr, ch_ack, ch_buff_wr;
  logic            sd_ack, sd_buff_wr;
  logic [31:0]     sd_lba;
  logic [7:0]      sd_buff_din;
  logic            busy, timeout_err;

  int n_pass  = 0;
  int n_total = 0;

  // Model: pending requests per channel and the fairness pointer.
  bit          m_rd [CH];
  bit          m_wr [CH];
  logic [31:0] m_lba[CH];
  logic [7:0]  m_buf[CH];
  int          m_ptr;

  sd_arbiter #(.CHANNELS(CH), .TIMEOUT(24'd16)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_rd      (req_rd),
    .req_wr      (req_wr),
    .req_lba     (req_lba),
    .req_buff_d  (req_buff_d),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .sd_lba      (sd_lba),
    .sd_buff_din (sd_buff_din),
    .sd_buff_wr  (sd_buff_wr),
    .ch_ack      (ch_ack),
    .ch_buff_wr  (ch_buff_wr),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int c = 0; c < CH; c++) begin
      req_rd[c]             = m_rd[c];
      req_wr[c]             = m_wr[c];
      req_lba[32*c +: 32]   = m_lba[c];
      req_buff_d[8*c +: 8]  = m_buf[c];
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < CH; k++)
      if (m_rd[(m_ptr + k) % CH] || m_wr[(m_ptr + k) % CH]) return (m_ptr + k) % CH;
    return -1;
  endfunction

  task automatic clear_model();
    for (int c = 0; c < CH; c++) begin
      m_rd[c] = 0; m_wr[c] = 0; m_lba[c] = '0; m_buf[c] = '0;
    end
    m_ptr = 0;
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
    clear_model();
    step(); step();
    reset = 1'b1;
    step();
  endtask

  // Called at the first negedge where the strobe for channel ch should be visible.
  task automatic txn(input int ch, input int delay, input logic [31:0] new_lba);
    logic [CH-1:0] oh;
    logic [31:0]   lba0;
    bit            rd;
    if (ch < 0) begin
      chk("model_pick", 32'hFFFF_FFFF, 32'h0);
      return;
    end
    oh   = CH'(1) << ch;
    rd   = m_rd[ch];
    lba0 = m_lba[ch];
    $display("txn ch=%0d %s lba=%08h delay=%0d", ch, rd ? "rd" : "wr", lba0, delay);
    chk("grant_rd", sd_rd, rd ? oh : '0);
    chk("grant_wr", sd_wr, rd ? '0 : oh);
    chk("grant_lba", sd_lba, lba0);
    chk("busy_req", busy, 1);
    repeat (delay) step();
    if (delay > 0) chk("hold_strobe", sd_rd | sd_wr, oh);
    sd_ack = 1'b1; sd_buff_wr = 1'b1;
    step();
    chk("xfer_strobe_off", sd_rd | sd_wr, 0);
    chk("ch_ack", ch_ack, oh);
    chk("ch_buff_wr", ch_buff_wr, oh);
    chk("buff_din", sd_buff_din, m_buf[ch]);
    m_rd[ch] = 0; m_wr[ch] = 0; m_lba[ch] = new_lba;
    drive();
    sd_buff_wr = 1'b0;
    step();
    chk("lba_hold", sd_lba, lba0);
    chk("busy_xfer", busy, 1);
    sd_ack = 1'b0;
    step();
    chk("busy_done", busy, 0);
    m_ptr = (ch + 1) % CH;
  endtask

  initial begin
    int n;
    bit got;
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    clear_model();

    // Asynchronous reset, observed before any clock edge.
    #2 reset = 1'b0;
    #1;
    chk("rst_sd_rd", sd_rd, 0);
    chk("rst_sd_wr", sd_wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lba", sd_lba, 0);
    chk("rst_terr", timeout_err, 0);
    step(); reset = 1'b1; step();

    // Single channel-0 read.
    m_rd[0] = 1; m_lba[0] = 32'h12; m_buf[0] = 8'hA5; drive();
    step(); txn(0, 0, 32'h12);

    // Channels 0 and 2 together from ptr=0.
    do_reset();
    m_rd[0] = 1; m_lba[0] = 32'h100; m_buf[0] = 8'h11;
    m_rd[2] = 1; m_lba[2] = 32'h300; m_buf[2] = 8'h33; drive();
    step(); txn(pick(), 1, 32'h100);
    step(); txn(pick(), 0, 32'h300);

    // Channel-1 write; its lba changes to 0x99 during the transfer.
    m_wr[1] = 1; m_lba[1] = 32'h3456; m_buf[1] = 8'h5C; drive();
    step(); txn(pick(), 1, 32'h99);

    // Channel-2 read that is never acknowledged.
    do_reset();
    m_rd[2] = 1; m_lba[2] = 32'h777; drive();
    step();
    chk("to_strobe", sd_rd, 3'b100);
    n = 0; got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      step(); n++;
      if (timeout_err) got = 1;
    end
    $display("timeout seen after %0d cycles", n);
    chk("timeout_cycle", n, 16);
    chk("timeout_idle", busy, 0);
    m_rd[2] = 0; drive();
    step();
    chk("timeout_pulse", timeout_err, 0);
    chk("timeout_stay_idle", busy, 0);

    // Stale ack in IDLE blocks the grant until it drops.
    sd_ack = 1'b1; m_rd[0] = 1; m_lba[0] = 32'hABC; m_buf[0] = 8'h42; drive();
    step(); step();
    chk("stale_busy", busy, 0);
    chk("stale_rd", sd_rd, 0);
    sd_ack = 1'b0;
    step(); txn(pick(), 0, 32'hABC);

    // Reset in the middle of a transfer restarts the pointer at 0.
    do_reset();
    m_rd[1] = 1; m_lba[1] = 32'h1111; drive();
    step(); txn(pick(), 0, 32'h1111);
    m_rd[0] = 1; m_lba[0] = 32'h2222; drive();
    step();
    chk("mid_grant", sd_rd, 3'b001);
    sd_ack = 1'b1;
    step();
    chk("mid_xfer_busy", busy, 1);
    m_rd[0] = 0; m_rd[1] = 1; m_lba[1] = 32'h4444; m_wr[2] = 1; m_lba[2] = 32'h5555;
    drive();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_rd", sd_rd, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_lba", sd_lba, 0);
    sd_ack = 1'b0;
    step();
    reset = 1'b1; m_ptr = 0;
    step(); txn(pick(), 0, 32'h4444);
    step(); txn(pick(), 2, 32'h5555);

    // Randomized traffic against the model.
    for (int i = 0; i < 30; i++) begin
      int any;
      any = 0;
      for (int c = 0; c < CH; c++) begin
        if (!(m_rd[c] || m_wr[c]) && $urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 2))
            0: begin m_rd[c] = 1; m_wr[c] = 0; end
            1: begin m_rd[c] = 0; m_wr[c] = 1; end
            default: begin m_rd[c] = 1; m_wr[c] = 1; end
          endcase
          m_lba[c] = $urandom;
        end
        m_buf[c] = 8'($urandom);
        if (m_rd[c] || m_wr[c]) any = 1;
      end
      if (any == 0) begin
        n = $urandom_range(0, CH - 1);
        m_wr[n] = 1; m_lba[n] = $urandom;
      end
      drive();
      step();
      txn(pick(), $urandom_range(0, 3), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sd_arbiter.md
SD_ARBITER -- requirements
Module: sd_arbiter

Interface
REQ-001 SHALL have parameter CHANNELS, default 3, number of sd requesters (drive A, drive B, SD card image).
REQ-002 SHALL have parameter TIMEOUT, default 24'd2800000, cycles to wait for sd_ack before abandoning a request.
REQ-003 SHALL have port clock  input  1: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port req_rd  input  CHANNELS: per-channel read request, held until that channel sees ack.
REQ-006 SHALL have port req_wr  input  CHANNELS: per-channel write request, same rule.
REQ-007 SHALL have port req_lba  input  32*CHANNELS: per-channel sector address, channel n at bits [32n+31:32n].
REQ-008 SHALL have port req_buff_d  input  8*CHANNELS: per-channel write-buffer byte, channel n at bits [8n+7:8n].
REQ-009 SHALL have port sd_rd  output  CHANNELS: read strobes to user_io, at most one bit set.
REQ-010 SHALL have port sd_wr  output  CHANNELS: write strobes to user_io, at most one bit set.
REQ-011 SHALL have port sd_ack  input  1: user_io transfer acknowledge.
REQ-012 SHALL have port sd_lba  output  32: sector address of the granted channel.
REQ-013 SHALL have port sd_buff_din  output  8: write byte of the granted channel.
REQ-014 SHALL have port sd_buff_wr  input  1: user_io buffer write strobe.
REQ-015 SHALL have port ch_ack  output  CHANNELS: sd_ack routed to the granted channel only.
REQ-016 SHALL have port ch_buff_wr  output  CHANNELS: sd_buff_wr routed to the granted channel only.
REQ-017 SHALL have port busy  output  1: high in any state other than IDLE.
REQ-018 SHALL have port timeout_err  output  1: one-cycle pulse when a request is abandoned.

Function
REQ-019 SHALL implement states IDLE, REQ, XFER.
REQ-020 IDLE: when any channel has req_rd|req_wr, SHALL grant the first requesting channel at or after round-robin pointer ptr, latch its lba and its direction, and enter REQ next cycle.
REQ-021 SHALL register grant, so sd_rd/sd_wr assert exactly one cycle after the request is first seen in IDLE.
REQ-022 Simultaneous req_rd and req_wr on the granted channel SHALL be issued as a read only.
REQ-023 REQ: SHALL drive the latched strobe; on sd_ack=1 SHALL enter XFER and deassert sd_rd/sd_wr.
REQ-024 REQ: if the granted channel drops both requests before ack, SHALL return to IDLE with no error.
REQ-025 REQ: a counter SHALL count from 0; on reaching TIMEOUT-1 without ack, SHALL return to IDLE and pulse timeout_err.
REQ-026 XFER: on sd_ack falling to 0, SHALL return to IDLE and set ptr to granted channel + 1, wrapping CHANNELS-1 to 0.
REQ-027 sd_lba SHALL be held at the latched value from grant until the next grant, never following req_lba mid-transfer.
REQ-028 sd_buff_din, ch_ack and ch_buff_wr SHALL be combinational from the current grant index; non-granted bits SHALL be 0.
REQ-029 sd_ack high while in IDLE (stale ack) SHALL be ignored; no grant is issued until it is low.

Reset
REQ-030 On reset low SHALL enter IDLE with ptr=0, grant=0, counter=0, sd_rd=0, sd_wr=0, sd_lba=0, busy=0, timeout_err=0, asynchronously, including mid-transfer.

Structure
REQ-031 SHALL place the state enum and the default TIMEOUT constant in shared package sd_pkg.
REQ-032 SHALL use one sub-module, rr_pick, returning the first set request bit at or after ptr with wrap-around.

Verification
REQ-033 Channel 0 read, lba=32'h12 -> sd_rd=3'b001 one cycle later, sd_lba=32'h12, ch_ack=3'b001 during ack.
REQ-034 Channels 0 and 2 request together, ptr=0 -> ch0 served, then ch2, with sd_rd never two bits set.
REQ-035 ch1 write with ch1 req_lba changed to 32'h99 during XFER -> sd_lba stays at the original value.
REQ-036 ch2 read, ack never arrives, TIMEOUT=16 -> timeout_err pulses once at cycle 16 of REQ, then IDLE.
REQ-037 Reset low during XFER -> sd_rd=0, busy=0 immediately; pending ch1 after release granted at ptr=0 order.
